// File: rtl/dac_arb_pkg.sv
// Shared types and sizing helpers for the DAC update arbiter.
package dac_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  localparam int unsigned FRAME_W = 16;

  // One counter serves both the busy timeout and the inter-frame gap.
  function automatic int unsigned cnt_width(input int unsigned timeout,
                                            input int unsigned gap);
    int unsigned m;
    m = (timeout > gap) ? timeout : gap;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(64, 4);

endpackage

// File: rtl/dac_update_arbiter_if.sv
// Requester and DAC transmitter signals of the DAC update arbiter.
interface dac_update_arbiter_if #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DATA_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        grant;
  logic                    dac_start;
  logic [DATA_W-1:0]       dac_data;
  logic                    dac_busy;

  // Arbiter side.
  modport master (
    input  req, req_data, dac_busy,
    output ack, grant, dac_start, dac_data
  );

  // Requesters and transmitter side.
  modport slave (
    output req, req_data, dac_busy,
    input  ack, grant, dac_start, dac_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_update_arbiter.sv
// Shares one serial DAC transmitter between N_REQ sample requesters.
module dac_update_arbiter
  import dac_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_update_arbiter_if.master bus,
  output logic                 err_timeout,
  output logic [FRAME_W-1:0]   frame_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W_L = cnt_width(TIMEOUT, GAP_CYC);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W_L-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                err_q, err_d;
  logic [FRAME_W-1:0]  frame_count_q, frame_count_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic                arb_valid;
  logic [IDX_W-1:0]    arb_idx;
  logic [DATA_W-1:0]   slices [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slices[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Next-state logic for the transaction FSM, counters and latches.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    ack_d         = '0;
    err_d         = err_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          data_d  = slices[arb_idx];
          ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.dac_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CNT_W_L'(TIMEOUT - 1)) begin
          // Transmitter never answered: release the requester without counting a frame.
          err_d   = 1'b1;
          ack_d   = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!bus.dac_busy) begin
          ack_d         = grant_q;
          frame_count_d = frame_count_q + 1'b1;
          grant_d       = '0;
          cnt_d         = '0;
          state_d       = StGap;
        end
      end
      StGap: begin
        if (cnt_q == CNT_W_L'(GAP_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      grant_q       <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.dac_start = (state_q == StIssue);
  assign bus.dac_data  = data_q;
  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign err_timeout   = err_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Self-checking bench for dac_update_arbiter with a scoreboard of expected transactions.
module tb_dac_update_arbiter;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GAP_CYC = 4;
  localparam int unsigned TIMEOUT = 64;

  typedef struct packed {
    logic [N_REQ-1:0]  grant;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_timeout;
  logic [15:0] frame_count;

  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_len    = 18;
  logic busy_en     = 1'b1;
  int   busy_cnt;

  txn_t             exp_q[$];
  logic [N_REQ-1:0] ack_exp_q[$];
  txn_t             mon_t;
  logic [N_REQ-1:0] mon_a;

  dac_update_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  dac_update_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .GAP_CYC (GAP_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_timeout (err_timeout),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises on the edge that ends the start pulse, stays up busy_len cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (bus.dac_start && busy_en) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.dac_busy = (busy_cnt != 0);

  // Scoreboard monitor: every start and every ack must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.dac_start === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL start_unexpected: got grant=%b data=%h, required no start",
                   bus.grant, bus.dac_data);
        end else begin
          mon_t = exp_q.pop_front();
          if (bus.grant !== mon_t.grant || bus.dac_data !== mon_t.data) begin
            miscompares++;
            $display("FAIL start_txn: got grant=%b data=%h, required grant=%b data=%h",
                     bus.grant, bus.dac_data, mon_t.grant, mon_t.data);
          end
          ack_exp_q.push_back(mon_t.grant);
        end
      end
      if (bus.ack !== '0) begin
        vectors++;
        if (ack_exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: got ack=%b, required none", bus.ack);
        end else begin
          mon_a = ack_exp_q.pop_front();
          if (bus.ack !== mon_a) begin
            miscompares++;
            $display("FAIL ack_value: got ack=%b, required %b", bus.ack, mon_a);
          end
        end
      end
    end
  end

  task automatic wait_start(output int n);
    n = 0;
    while (bus.dac_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_start: got no dac_start in %0d cycles, required one", n);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (bus.ack === '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ack: got no ack in %0d cycles, required one", n);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0;
    exp_q.delete();
    ack_exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    vectors += 6;
    if (bus.ack !== '0) begin miscompares++; $display("FAIL rst_ack: got %b, required 0", bus.ack); end
    if (bus.grant !== '0) begin miscompares++; $display("FAIL rst_grant: got %b, required 0", bus.grant); end
    if (bus.dac_start !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %b, required 0", bus.dac_start); end
    if (bus.dac_data !== '0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", bus.dac_data); end
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b, required 0", err_timeout); end
    if (frame_count !== 16'h0) begin miscompares++; $display("FAIL rst_count: got %h, required 0", frame_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    busy_len = 18;
    bus.req_data = {8'h00, 8'hA5};
    bus.req = 2'b01;
    exp_q.push_back('{2'b01, 8'hA5});
    wait_start(n);
    // Grant edge, then the start pulse in the ISSUE cycle that follows.
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL single_latency: got %0d, required 1", n); end
    wait_ack(n);
    // 1 ISSUE-to-busy cycle, 18 busy cycles, then ack one cycle after busy falls.
    vectors += 2;
    if (n !== 20) begin miscompares++; $display("FAIL single_ack_delay: got %0d, required 20", n); end
    if (frame_count !== 16'd1) begin miscompares++; $display("FAIL single_count: got %0d, required 1", frame_count); end
    exp_q.push_back('{2'b01, 8'hA5});
    wait_start(n);
    // Four GAP cycles, one IDLE cycle, then ISSUE.
    vectors++;
    if (n !== GAP_CYC + 1) begin miscompares++; $display("FAIL single_gap: got %0d, required %0d", n, GAP_CYC + 1); end
    wait_ack(n);
    bus.req = '0;
    vectors++;
    if (frame_count !== 16'd2) begin miscompares++; $display("FAIL single_count2: got %0d, required 2", frame_count); end
  endtask

  task automatic test_contention();
    int n;
    apply_reset();
    bus.req_data = {8'h22, 8'h11};
    bus.req = 2'b11;
    exp_q.push_back('{2'b01, 8'h11});
    exp_q.push_back('{2'b10, 8'h22});
    exp_q.push_back('{2'b01, 8'h11});
    exp_q.push_back('{2'b10, 8'h22});
    for (int k = 0; k < 4; k++) begin
      wait_start(n);
      wait_ack(n);
    end
    bus.req = '0;
    vectors++;
    if (frame_count !== 16'd4) begin miscompares++; $display("FAIL cont_count: got %0d, required 4", frame_count); end
  endtask

  task automatic test_timeout();
    int n;
    busy_en = 1'b0;
    bus.req_data = {8'h5A, 8'h11};
    bus.req = 2'b10;
    exp_q.push_back('{2'b10, 8'h5A});
    wait_start(n);
    repeat (TIMEOUT) @(negedge clk);
    vectors += 2;
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_early_err: got %b, required 0", err_timeout); end
    if (bus.ack !== '0) begin miscompares++; $display("FAIL to_early_ack: got %b, required 0", bus.ack); end
    @(negedge clk);
    vectors += 3;
    if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b, required 1", err_timeout); end
    if (bus.ack !== 2'b10) begin miscompares++; $display("FAIL to_ack: got %b, required 10", bus.ack); end
    if (frame_count !== 16'd4) begin miscompares++; $display("FAIL to_count: got %0d, required 4", frame_count); end
    bus.req = '0;
    busy_en = 1'b1;
    bus.req_data = {8'h00, 8'h77};
    bus.req = 2'b01;
    exp_q.push_back('{2'b01, 8'h77});
    wait_start(n);
    wait_ack(n);
    bus.req = '0;
    vectors += 2;
    if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b, required 1", err_timeout); end
    if (frame_count !== 16'd5) begin miscompares++; $display("FAIL to_count2: got %0d, required 5", frame_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    bus.req_data = {8'h00, 8'h99};
    bus.req = 2'b01;
    exp_q.push_back('{2'b01, 8'h99});
    wait_start(n);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    exp_q.delete();
    ack_exp_q.delete();
    #1;
    vectors += 5;
    if (bus.grant !== '0) begin miscompares++; $display("FAIL mid_grant: got %b, required 0", bus.grant); end
    if (bus.dac_start !== 1'b0) begin miscompares++; $display("FAIL mid_start: got %b, required 0", bus.dac_start); end
    if (bus.dac_data !== '0) begin miscompares++; $display("FAIL mid_data: got %h, required 0", bus.dac_data); end
    if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL mid_err: got %b, required 0", err_timeout); end
    if (frame_count !== 16'h0) begin miscompares++; $display("FAIL mid_count: got %h, required 0", frame_count); end
    @(negedge clk);
    rst = 1'b0;
    // The pointer had advanced to 1; after reset requester 0 must win first.
    bus.req_data = {8'hBB, 8'hAA};
    bus.req = 2'b11;
    exp_q.push_back('{2'b01, 8'hAA});
    exp_q.push_back('{2'b10, 8'hBB});
    for (int k = 0; k < 2; k++) begin
      wait_start(n);
      wait_ack(n);
    end
    bus.req = '0;
  endtask

  task automatic test_data_stable();
    int n;
    int bad;
    bus.req_data = {8'h00, 8'h33};
    bus.req = 2'b01;
    exp_q.push_back('{2'b01, 8'h33});
    wait_start(n);
    repeat (5) @(negedge clk);
    bus.req_data = {8'h00, 8'h44};
    n = 0;
    bad = 0;
    while (bus.ack === '0 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.dac_data !== 8'h33) bad++;
    end
    exp_q.push_back('{2'b01, 8'h44});
    while (bus.dac_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.dac_start !== 1'b1 && bus.dac_data !== 8'h33) bad++;
    end
    vectors++;
    if (bad != 0 || n >= 200) begin
      miscompares++;
      $display("FAIL data_hold: got %0d changed cycles (%0d waited), required 0", bad, n);
    end
    wait_ack(n);
    bus.req = '0;
  endtask

  task automatic test_wrap();
    int n;
    repeat (GAP_CYC + 2) @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.frame_count_q;
    @(negedge clk);
    vectors++;
    if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload: got %h, required ffff", frame_count); end
    bus.req_data = {8'hC3, 8'h00};
    bus.req = 2'b10;
    exp_q.push_back('{2'b10, 8'hC3});
    wait_start(n);
    wait_ack(n);
    bus.req = '0;
    vectors++;
    if (frame_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_count: got %h, required 0000", frame_count); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_data_stable();
    test_wrap();
    repeat (10) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || ack_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d starts and %0d acks outstanding, required 0",
               exp_q.size(), ack_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
